// File: rtl/vga_param_disp_ctrl.sv
// Parametrised VGA timing generator with frame-latched colour and registered, mutually aligned outputs.
// Optional vertical colour-bar test pattern is built when VGA_TESTPAT_EN is defined.
module vga_param_disp_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned COLOR_BITS = 3,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    localparam int unsigned H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW        = $clog2(H_TOT),
    localparam int unsigned YW        = $clog2(V_TOT),
    localparam int unsigned RW        = 3 * COLOR_BITS
) (
    input  logic          pixelClk,
    input  logic          reset,
    input  logic [2:0]    inColor,
`ifdef VGA_TESTPAT_EN
    input  logic          testMode,
`endif
    output logic [RW-1:0] vgaRGB,
    output logic          vgaHsync,
    output logic          vgaVsync,
    output logic          activeVideo,
    output logic [XW-1:0] pixelX,
    output logic [YW-1:0] pixelY,
    output logic          frameStart
);

    localparam logic [XW-1:0] H_LAST = XW'(H_TOT - 1);
    localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SS   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOT - 1);
    localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SS   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SE   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] hCnt;
    logic [YW-1:0] vCnt;
    logic [2:0]    colorLatch;
    logic          atOrigin_c;
    logic          active_c;
    logic          hsyncOn_c;
    logic          vsyncOn_c;
    logic [2:0]    colorNow_c;
    logic [2:0]    code_c;
    logic [RW-1:0] rgb_c;

    // Raster counters
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + YW'(1);
        end else begin
            hCnt <= hCnt + XW'(1);
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam int unsigned BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int unsigned BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    logic [BW-1:0] barCnt;
    logic [2:0]    barIdx;
    logic          modeLatch;
    logic          modeNow_c;

    // Bar index tracks hCnt / BAR_W by counting bar widths, saturating at the last bar
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            barCnt <= '0;
            barIdx <= '0;
        end else if (hCnt == H_LAST) begin
            barCnt <= '0;
            barIdx <= '0;
        end else if (barCnt == BAR_LAST) begin
            barCnt <= '0;
            if (barIdx != 3'd7) begin
                barIdx <= barIdx + 3'd1;
            end
        end else begin
            barCnt <= barCnt + BW'(1);
        end
    end

    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            modeLatch <= 1'b0;
        end else if (atOrigin_c) begin
            modeLatch <= testMode;
        end
    end
`endif

    // Colour is held for the whole frame to avoid tearing
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            colorLatch <= '0;
        end else if (atOrigin_c) begin
            colorLatch <= inColor;
        end
    end

    // At (0,0) the value being latched is also the one shown, so the new frame starts clean
    always_comb begin
        atOrigin_c = (hCnt == '0) && (vCnt == '0);
        active_c   = (hCnt < H_ACT) && (vCnt < V_ACT);
        hsyncOn_c  = (hCnt >= H_SS) && (hCnt < H_SE);
        vsyncOn_c  = (vCnt >= V_SS) && (vCnt < V_SE);
        colorNow_c = atOrigin_c ? inColor : colorLatch;
`ifdef VGA_TESTPAT_EN
        modeNow_c  = atOrigin_c ? testMode : modeLatch;
        code_c     = modeNow_c ? (3'd7 - barIdx) : colorNow_c;
`else
        code_c     = colorNow_c;
`endif
        rgb_c      = '0;
        if (active_c) begin
            rgb_c = {{COLOR_BITS{code_c[2]}}, {COLOR_BITS{code_c[1]}}, {COLOR_BITS{code_c[0]}}};
        end
    end

    // Output stage: everything derived from the same counter state, one cycle late
    always_ff @(posedge pixelClk or negedge reset) begin
        if (!reset) begin
            vgaRGB      <= '0;
            vgaHsync    <= ~HSYNC_POL;
            vgaVsync    <= ~VSYNC_POL;
            activeVideo <= 1'b0;
            pixelX      <= '0;
            pixelY      <= '0;
            frameStart  <= 1'b0;
        end else begin
            vgaRGB      <= rgb_c;
            vgaHsync    <= hsyncOn_c ? HSYNC_POL : ~HSYNC_POL;
            vgaVsync    <= vsyncOn_c ? VSYNC_POL : ~VSYNC_POL;
            activeVideo <= active_c;
            pixelX      <= hCnt;
            pixelY      <= vCnt;
            frameStart  <= atOrigin_c;
        end
    end

endmodule

// File: tb/tb_vga_param_disp_ctrl.sv
// Self-checking bench for vga_param_disp_ctrl on a reduced 80x27 raster; covers the
// VGA_TESTPAT_EN bars when that macro is defined.
module tb_vga_param_disp_ctrl;

    localparam int unsigned XW = 7;
    localparam int unsigned YW = 5;

    logic          pixelClk = 1'b0;
    logic          reset;
    logic [2:0]    inColor;
    logic          testMode;
    logic [11:0]   vgaRGB;
    logic          vgaHsync;
    logic          vgaVsync;
    logic          activeVideo;
    logic [XW-1:0] pixelX;
    logic [YW-1:0] pixelY;
    logic          frameStart;

    vga_param_disp_ctrl #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .COLOR_BITS(4), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
    ) dut (
        .pixelClk(pixelClk),
        .reset(reset),
        .inColor(inColor),
`ifdef VGA_TESTPAT_EN
        .testMode(testMode),
`endif
        .vgaRGB(vgaRGB),
        .vgaHsync(vgaHsync),
        .vgaVsync(vgaVsync),
        .activeVideo(activeVideo),
        .pixelX(pixelX),
        .pixelY(pixelY),
        .frameStart(frameStart)
    );

    always #5 pixelClk = ~pixelClk;

    typedef struct packed {
        logic [11:0]   rgb;
        logic          hs;
        logic          vs;
        logic          av;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          fs;
    } outT;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    outT  q[$];
    int   mH = 0;
    int   mV = 0;
    logic [2:0] mColor = 3'b000;
    logic       mMode  = 1'b0;

    // Reference pixel built directly from the raster description
    function automatic outT expOf(int h, int v, logic [2:0] c, logic m);
        outT e;
        int idx;
        logic [2:0] code;
        idx = h / 8;
        if (idx > 7) idx = 7;
        code  = m ? 3'(7 - idx) : c;
        e.av  = (h < 64) && (v < 20);
        e.rgb = e.av ? {{4{code[2]}}, {4{code[1]}}, {4{code[0]}}} : 12'h000;
        e.hs  = (h >= 68 && h < 76) ? 1'b0 : 1'b1;
        e.vs  = (v >= 22 && v < 24) ? 1'b1 : 1'b0;
        e.x   = XW'(h);
        e.y   = YW'(v);
        e.fs  = (h == 0) && (v == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic outT curOut();
        outT o;
        o.rgb = vgaRGB; o.hs = vgaHsync; o.vs = vgaVsync; o.av = activeVideo;
        o.x = pixelX; o.y = pixelY; o.fs = frameStart;
        return o;
    endfunction

    task automatic checkReset(input string tag);
        outT e;
        e = '{rgb: 12'h000, hs: 1'b1, vs: 1'b0, av: 1'b0, x: '0, y: '0, fs: 1'b0};
        check(tag, 32'(curOut()), 32'(e));
    endtask

    // Push the expected pixel for this edge, advance the model, then compare after the edge
    task automatic tick();
        outT e;
        if (mH == 0 && mV == 0) begin
            mColor = inColor;
            mMode  = testMode;
        end
        q.push_back(expOf(mH, mV, mColor, mMode));
        if (mH == 79) begin
            mH = 0;
            mV = (mV == 26) ? 0 : mV + 1;
        end else begin
            mH = mH + 1;
        end
        @(posedge pixelClk);
        #1;
        cyc++;
        e = q.pop_front();
        check("stream", 32'(curOut()), 32'(e));
    endtask

    initial begin
        int h, v;
        int hsLow, firstLowX, vsHi, firstVsY, lastFs, fsPeriod;
        reset = 1'b1; inColor = 3'b101; testMode = 1'b0;
        #1 reset = 1'b0;
        #2 checkReset("reset_init");
        #9 reset = 1'b1;

        // Frame 1: sync widths, positions and colour map
        hsLow = 0; firstLowX = -1; vsHi = 0; firstVsY = -1; lastFs = -1; fsPeriod = 0;
        for (int i = 0; i < 2160; i++) begin
            h = mH; v = mV;
            tick();
            if (v == 0 && !vgaHsync) begin
                if (firstLowX < 0) firstLowX = int'(pixelX);
                hsLow++;
            end
            if (vgaVsync) begin
                if (firstVsY < 0) firstVsY = int'(pixelY);
                vsHi++;
            end
            if (frameStart) begin
                if (lastFs >= 0) fsPeriod = cyc - lastFs;
                lastFs = cyc;
            end
            if (h == 10 && v == 5) check("rgb_active", 32'(vgaRGB), 32'h0F0F);
            if (h == 70 && v == 5) check("rgb_blank", 32'(vgaRGB), 32'h0000);
        end
        check("hsync_width", 32'(hsLow), 32'd8);
        check("hsync_start_x", 32'(firstLowX), 32'd68);
        check("vsync_cycles", 32'(vsHi), 32'd160);
        check("vsync_start_y", 32'(firstVsY), 32'd22);

        // Frame 2: mid-frame colour change is ignored
        inColor = 3'b001;
        for (int i = 0; i < 2160; i++) begin
            h = mH; v = mV;
            if (h == 0 && v == 10) inColor = 3'b110;
            tick();
            if (frameStart) begin
                fsPeriod = cyc - lastFs;
                lastFs = cyc;
            end
            if (h == 10 && v == 5) check("blue_before_change", 32'(vgaRGB), 32'h000F);
            if (h == 10 && v == 15) check("blue_after_change", 32'(vgaRGB), 32'h000F);
        end
        check("frame_period", 32'(fsPeriod), 32'd2160);

        // Frame 3 picks up the new colour at (0,0)
        tick();
        check("new_colour_origin", 32'(vgaRGB), 32'h0FF0);
        check("new_frame_strobe", 32'(frameStart), 32'd1);

        // Asynchronous reset in mid-line
        h = -1; v = -1;
        for (int i = 0; i < 2200 && !(h == 30 && v == 12); i++) begin
            h = mH; v = mV;
            tick();
        end
        check("pre_reset_pos", 32'({pixelX, pixelY}), 32'({7'd30, 5'd12}));
        #2 reset = 1'b0;
        #1 checkReset("reset_async");
        q.delete();
        mH = 0; mV = 0; mColor = 3'b000; mMode = 1'b0;
        @(posedge pixelClk);
        #1 checkReset("reset_held");
        inColor = 3'b011;
        #2 reset = 1'b1;
        tick();
        check("release_strobe", 32'(frameStart), 32'd1);
        check("release_colour", 32'(vgaRGB), 32'h00FF);

        for (int i = 0; i < 2200 && !(mH == 0 && mV == 0); i++) tick();

`ifdef VGA_TESTPAT_EN
        // Colour bars: 8 px wide, white first, black last
        testMode = 1'b1;
        inColor  = 3'b001;
        for (int i = 0; i < 2160; i++) begin
            h = mH; v = mV;
            tick();
            if (v == 3 && h == 0)  check("bar_x0", 32'(vgaRGB), 32'h0FFF);
            if (v == 3 && h == 8)  check("bar_x8", 32'(vgaRGB), 32'h0FF0);
            if (v == 3 && h == 55) check("bar_x55", 32'(vgaRGB), 32'h000F);
            if (v == 3 && h == 63) check("bar_x63", 32'(vgaRGB), 32'h0000);
        end
        testMode = 1'b0;
        for (int i = 0; i < 100; i++) tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
